// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: owns the register file, flag bank and pc, and steps
// one instruction at a time through an external registered ALU (IDLE-DECODE-EXEC-WB).
module alu_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BRANCH_REG = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_word,
    output logic [31:0] pc,
    output logic        done,
    output logic        illegal,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [31:0] alu_reg8,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_F1,
    output logic        alu_F2,
    output logic [6:0]  alu_instr,
    input  logic [31:0] alu_C,
    input  logic        alu_F3,
    input  logic [31:0] alu_naddr
);

    localparam logic [3:0] BRANCH_IDX = 4'(BRANCH_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    logic [31:0] regs [16];
    logic [3:0]  flags;
    logic [31:0] pc_inc;

    logic [6:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        highlow;
    logic [15:0] value;
    logic [1:0]  fs1;
    logic [1:0]  fs2;
    logic [1:0]  fd;

    // The register and flag selectors overlap the immediate field by design.
    assign op      = instr_q[31:25];
    assign rd      = instr_q[24:21];
    assign ra      = instr_q[20:17];
    assign highlow = instr_q[16];
    assign value   = instr_q[15:0];
    assign rb      = instr_q[15:12];
    assign fs1     = instr_q[11:10];
    assign fs2     = instr_q[9:8];
    assign fd      = instr_q[7:6];

    assign pc_inc  = pc + 32'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
        end else if (state == S_IDLE && instr_valid) begin
            instr_q <= instr_word;
        end
    end

    // Operands are captured once in DECODE and then held until the next DECODE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_A       <= '0;
            alu_B       <= '0;
            alu_reg8    <= '0;
            alu_value   <= '0;
            alu_highlow <= 1'b0;
            alu_F1      <= 1'b0;
            alu_F2      <= 1'b0;
            alu_instr   <= '0;
        end else if (state == S_DECODE) begin
            alu_A       <= regs[ra];
            alu_B       <= regs[rb];
            alu_reg8    <= regs[BRANCH_IDX];
            alu_value   <= value;
            alu_highlow <= highlow;
            alu_F1      <= flags[fs1];
            alu_F2      <= flags[fs2];
            alu_instr   <= op;
        end
    end

    // NOTE: the register file is reset explicitly because software relies on
    // every register reading zero after reset; this keeps it out of RAM macros.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            flags   <= '0;
            pc      <= RESET_PC;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            if (state == S_WB) begin
                done <= 1'b1;
                case (op) inside
                    [7'd0:7'd7]: begin
                        regs[rd] <= alu_C;
                        pc       <= pc_inc;
                    end
                    [7'd8:7'd13]: begin
                        flags[fd] <= alu_F3;
                        pc        <= pc_inc;
                    end
                    7'd14: pc <= alu_naddr;
                    // Conditional branch uses the flag latched in DECODE, not ALU addrch.
                    7'd15: pc <= alu_F1 ? alu_naddr : pc_inc;
                    default: begin
                        illegal <= 1'b1;
                        pc      <= pc_inc;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stand-in, a reference model of
// registers/flags/pc, and a scoreboard of expected retirements compared on each done pulse.
module tb_alu_sequencer;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr_word = '0;
    logic [31:0] pc;
    logic        done;
    logic        illegal;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [31:0] alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow;
    logic        alu_F1;
    logic        alu_F2;
    logic [6:0]  alu_instr;
    logic [31:0] alu_C = '0;
    logic        alu_F3 = 1'b0;
    logic [31:0] alu_naddr = '0;

    alu_sequencer #(
        .RESET_PC  (TB_RESET_PC),
        .BRANCH_REG(8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_word (instr_word),
        .pc         (pc),
        .done       (done),
        .illegal    (illegal),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_reg8   (alu_reg8),
        .alu_value  (alu_value),
        .alu_highlow(alu_highlow),
        .alu_F1     (alu_F1),
        .alu_F2     (alu_F2),
        .alu_instr  (alu_instr),
        .alu_C      (alu_C),
        .alu_F3     (alu_F3),
        .alu_naddr  (alu_naddr)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ALU behaviour used both by the stand-in and by the reference model.
    function automatic logic [31:0] alu_c_fn(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [15:0] v,
                                             input logic hl);
        case (op)
            7'd0:    return a + b;
            7'd1:    return a - b;
            7'd2:    return a & b;
            7'd3:    return a | b;
            7'd4:    return a ^ b;
            7'd5:    return hl ? {v, 16'h0000} : {16'h0000, v};
            7'd6:    return a << b[4:0];
            7'd7:    return a >> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic alu_f3_fn(input logic [6:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic f1, input logic f2);
        case (op)
            7'd8:    return a == b;
            7'd9:    return a < b;
            7'd10:   return f1 & f2;
            7'd11:   return f1 | f2;
            7'd12:   return ~f1;
            7'd13:   return a != b;
            default: return 1'b1;
        endcase
    endfunction

    // Registered ALU stand-in: samples operands every edge, result visible next cycle.
    always @(posedge clock) begin
        alu_C     <= alu_c_fn(alu_instr, alu_A, alu_B, alu_value, alu_highlow);
        alu_F3    <= alu_f3_fn(alu_instr, alu_A, alu_B, alu_F1, alu_F2);
        alu_naddr <= alu_reg8;
    end

    function automatic logic [15:0] mk(input logic [3:0] rb, input logic [1:0] fs1,
                                       input logic [1:0] fs2, input logic [1:0] fd);
        return {rb, fs1, fs2, fd, 6'b0};
    endfunction

    typedef struct {
        string       tag;
        int          acc;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r8;
        logic [15:0] v;
        logic        hl;
        logic [6:0]  op;
        logic        f1;
        logic        f2;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    logic [31:0] m_pc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_flags = '0;
        m_pc    = TB_RESET_PC;
    endtask

    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_latency"}, 32'(cyc - e.acc), 32'd3);
                check({e.tag, "_pc"}, pc, e.pc);
                check({e.tag, "_illegal"}, 32'(illegal), 32'(e.ill));
                check({e.tag, "_alu_A"}, alu_A, e.a);
                check({e.tag, "_alu_B"}, alu_B, e.b);
                check({e.tag, "_alu_reg8"}, alu_reg8, e.r8);
                check({e.tag, "_alu_value"}, 32'(alu_value), 32'(e.v));
                check({e.tag, "_alu_highlow"}, 32'(alu_highlow), 32'(e.hl));
                check({e.tag, "_alu_instr"}, 32'(alu_instr), 32'(e.op));
                check({e.tag, "_alu_F1"}, 32'(alu_F1), 32'(e.f1));
                check({e.tag, "_alu_F2"}, 32'(alu_F2), 32'(e.f2));
            end
        end else if (illegal) begin
            check("illegal_without_done", 32'(illegal), 32'd0);
        end
    end

    // Drive one instruction, push its expected retirement, wait (bounded) for it to retire.
    task automatic issue(input string tag, input logic [6:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic hl, input logic [15:0] v,
                         input bit hold);
        exp_t        e;
        logic [31:0] c;
        logic        f3;
        e.tag = tag;
        e.op  = op;
        e.v   = v;
        e.hl  = hl;
        e.a   = m_regs[ra];
        e.b   = m_regs[v[15:12]];
        e.r8  = m_regs[8];
        e.f1  = m_flags[v[11:10]];
        e.f2  = m_flags[v[9:8]];
        e.ill = (op > 7'd15);
        e.acc = 0;
        c     = alu_c_fn(op, e.a, e.b, v, hl);
        f3    = alu_f3_fn(op, e.a, e.b, e.f1, e.f2);
        e.pc  = m_pc + 32'd1;
        if (op < 7'd8) m_regs[rd] = c;
        else if (op < 7'd14) m_flags[v[7:6]] = f3;
        else if (op == 7'd14) e.pc = e.r8;
        else if (op == 7'd15 && e.f1) e.pc = e.r8;
        m_pc = e.pc;

        @(negedge clock);
        check({tag, "_ready"}, 32'(instr_ready), 32'd1);
        instr_word  = {op, rd, ra, hl, v};
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        if (hold) begin
            instr_word = 32'hFFFF_FFFF;
            @(negedge clock);
            check({tag, "_busy"}, 32'(instr_ready), 32'd0);
            repeat (3) @(negedge clock);
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset_pc", pc, TB_RESET_PC);
        check("reset_ready", 32'(instr_ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_alu_instr", 32'(alu_instr), 32'd0);
        check("reset_alu_A", alu_A, 32'd0);

        issue("zero_read", 7'd0, 4'd0, 4'd0, 1'b0, mk(4'd1, 2'd1, 2'd2, 2'd0), 1'b0);
        issue("load_r1", 7'd5, 4'd1, 4'd0, 1'b0, 16'h1234, 1'b0);
        issue("add_r2", 7'd0, 4'd2, 4'd1, 1'b0, mk(4'd1, 2'd0, 2'd0, 2'd0), 1'b0);
        issue("load_r3", 7'd5, 4'd3, 4'd0, 1'b0, 16'h0007, 1'b0);
        issue("load_r4", 7'd5, 4'd4, 4'd0, 1'b0, 16'h0007, 1'b0);
        issue("load_r5", 7'd5, 4'd5, 4'd0, 1'b0, 16'h0008, 1'b0);
        issue("eq_set", 7'd8, 4'd0, 4'd3, 1'b0, mk(4'd4, 2'd0, 2'd0, 2'd3), 1'b0);
        issue("eq_clr", 7'd8, 4'd0, 4'd3, 1'b0, mk(4'd5, 2'd3, 2'd3, 2'd3), 1'b0);
        issue("br_not", 7'd15, 4'd0, 4'd0, 1'b0, mk(4'd0, 2'd3, 2'd0, 2'd0), 1'b0);
        issue("load_r8", 7'd5, 4'd8, 4'd0, 1'b0, 16'h0040, 1'b0);
        issue("eq_set2", 7'd8, 4'd0, 4'd3, 1'b0, mk(4'd4, 2'd0, 2'd0, 2'd3), 1'b0);
        issue("br_taken", 7'd15, 4'd0, 4'd0, 1'b0, mk(4'd0, 2'd3, 2'd3, 2'd0), 1'b0);
        issue("load_r8b", 7'd5, 4'd8, 4'd0, 1'b0, 16'h0099, 1'b0);
        issue("jump", 7'd14, 4'd0, 4'd0, 1'b0, mk(4'd0, 2'd0, 2'd0, 2'd0), 1'b0);
        issue("illegal_op", 7'h20, 4'd2, 4'd1, 1'b0, mk(4'd1, 2'd0, 2'd0, 2'd0), 1'b0);
        issue("post_illegal", 7'd2, 4'd6, 4'd2, 1'b0, mk(4'd1, 2'd0, 2'd3, 2'd0), 1'b0);
        issue("load_r9", 7'd5, 4'd9, 4'd0, 1'b0, 16'hFFFF, 1'b0);
        issue("load_r10", 7'd5, 4'd10, 4'd0, 1'b1, 16'hFFFF, 1'b0);
        issue("or_r8", 7'd3, 4'd8, 4'd9, 1'b0, mk(4'd10, 2'd0, 2'd0, 2'd0), 1'b0);
        issue("jump_max", 7'd14, 4'd0, 4'd0, 1'b0, mk(4'd0, 2'd0, 2'd0, 2'd0), 1'b0);
        issue("pc_wrap", 7'd4, 4'd11, 4'd8, 1'b0, mk(4'd6, 2'd0, 2'd0, 2'd0), 1'b0);
        issue("hold_sub", 7'd1, 4'd12, 4'd2, 1'b0, mk(4'd1, 2'd0, 2'd0, 2'd0), 1'b1);
        issue("read_r12", 7'd0, 4'd13, 4'd12, 1'b0, mk(4'd11, 2'd3, 2'd0, 2'd0), 1'b0);

        // Abort an instruction in EXEC with reset; it must not retire or write back.
        @(negedge clock);
        instr_word  = {7'd0, 4'd1, 4'd1, 1'b0, mk(4'd2, 2'd0, 2'd0, 2'd0)};
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_pc", pc, TB_RESET_PC);
        check("abort_ready", 32'(instr_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_alu_instr", 32'(alu_instr), 32'd0);
        check("abort_alu_A", alu_A, 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("abort_pc_held", pc, TB_RESET_PC);

        issue("after_abort", 7'd0, 4'd0, 4'd1, 1'b0, mk(4'd2, 2'd3, 2'd1, 2'd0), 1'b0);

        repeat (6) @(negedge clock);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle execute controller that owns the 16x32 register file, the 4-bit flag bank and the program counter, and sequences one instruction at a time through the registered ALU. Sits between instruction fetch (valid/ready handshake) and the ALU instance. Decodes the instruction word, drives ALU operands, waits for the ALU's clocked result, then writes back, updates flags and resolves branches.

Parameters:
RESET_PC, 0, pc value after reset
BRANCH_REG, 8, register index driven onto the ALU reg8 input

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instr_word is valid
instr_ready  out  1  sequencer can accept an instruction
instr_word  in  32  [31:25] opcode, [24:21] rd, [20:17] ra, [16] highlow, [15:0] value; [15:12] rb, [11:10] fs1, [9:8] fs2, [7:6] fd
pc  out  32  address of the next instruction to fetch
done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse, coincident with done, for opcode > 15
alu_A, alu_B, alu_reg8  out  32 each  ALU operands
alu_value  out  16  ALU immediate
alu_highlow, alu_F1, alu_F2  out  1 each  ALU controls/flag inputs
alu_instr  out  7  ALU opcode
alu_C  in  32  ALU result
alu_F3  in  1  ALU flag result
alu_naddr  in  32  ALU branch target

Behaviour:
- Reset (async, reset_n low): state IDLE, pc=RESET_PC, all registers and flags 0, all alu_* outputs 0, done=illegal=0, instr_ready=1 on release. Reset mid-instruction aborts it: no writeback, no pc change.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE. One instruction in flight, no pipelining.
- IDLE: instr_ready=1. On instr_valid&&instr_ready at edge T, latch instr_word; go DECODE. instr_ready=0 in all other states.
- DECODE (T+1): register alu_A=R[ra], alu_B=R[rb], alu_reg8=R[BRANCH_REG], alu_value, alu_highlow, alu_F1=flag[fs1], alu_F2=flag[fs2], alu_instr=opcode.
- EXEC (T+2): operands held stable; the ALU samples them at the end of this cycle.
- WB (T+3): sample alu_C/alu_F3/alu_naddr. done=1. Total latency: accept edge to done = 3 cycles; next accept no earlier than T+4.
  - opcode 0-7: R[rd] <= alu_C. pc <= pc+1.
  - opcode 8-13: flag[fd] <= alu_F3. pc <= pc+1. Registers unchanged.
  - opcode 14: pc <= alu_naddr (unconditional).
  - opcode 15: if alu_F1 (latched flag[fs1]) then pc <= alu_naddr, else pc <= pc+1.
  - opcode 16-127: illegal=1, no writeback, pc <= pc+1.
- The ALU addrch output is not used (it is sticky); branch decisions come from opcode and flag bank only.
- pc increments wrap modulo 2^32 (0xFFFFFFFF+1 = 0).
- rd = ra or rb is legal: operands are read in DECODE, before writeback.
- Register 0 is an ordinary writable register.
- instr_valid asserted outside IDLE is ignored; instr_word is not re-sampled.
- alu_* outputs hold their last values after WB until the next DECODE.

Test Plan:
- Reset with instr_valid=0 -> pc=RESET_PC, instr_ready=1, done=0, alu_instr=0; all register and flag reads return 0.
- Load R1 via opcode 5 (highlow=0, value=0x1234), then opcode 0 with rd=2, ra=1, rb=1 -> done exactly 3 cycles after each accept; R[2] equals alu_C at WB; pc advanced by 2.
- Opcode 8 with R[ra]=R[rb]=7, fd=3 -> flag[3]=1, registers unchanged; repeat with R[rb]=8 -> flag[3]=0.
- Opcode 15 with flag[fs1]=0 -> pc=pc+1; with flag[fs1]=1 and R[8]=0x40 -> pc=alu_naddr; opcode 14 -> pc=alu_naddr unconditionally.
- Opcode 0x20 -> illegal and done pulse together, no register or flag change, pc+1; pc=0xFFFFFFFF followed by opcode 4 -> pc=0.
- Assert reset_n low while in EXEC -> immediate IDLE, no writeback; instr_valid held high during DECODE/EXEC/WB -> exactly one instruction accepted.
